// File: rtl/mem_bus_arbiter.sv
// Two-requester shared-bus controller (fetch F, execute E) for GPR file and RAM.
// Define ARB_RR_EN for round-robin arbitration; fixed E-over-F priority otherwise.
module mem_bus_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic          f_tgt,
    input  logic          f_read,
    input  logic [AW-1:0] f_addr,
    input  logic [DW-1:0] f_wdata,
    input  logic          e_req,
    input  logic          e_tgt,
    input  logic          e_read,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    output logic          f_gnt,
    output logic          e_gnt,
    output logic          f_done,
    output logic          e_done,
    output logic          f_err,
    output logic          e_err,
    output logic [DW-1:0] rdata,
    output logic          cs_gpr,
    output logic          cs_ram,
    output logic          bus_read,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_oe,
    input  logic          ready_gpr,
    input  logic          ready_ram,
    input  logic [DW-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] TMO_C = 4'(TMO);

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n, cnt_inc;
    logic          own_e, own_e_n;
    logic          tgt_q, tgt_n;
    logic          read_q, read_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;
    logic [DW-1:0] rdata_n;
    logic          drive, fin, fin_err;
    logic          rdy, pick_e;

    assign rdy     = tgt_q ? ready_ram : ready_gpr;
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

`ifdef ARB_RR_EN
    // ptr_e records the last winner; a tie goes to the other requester
    logic ptr_e;

    assign pick_e = e_req & (~f_req | ~ptr_e);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_e <= 1'b1;
        end else if (state == S_IDLE && (f_req | e_req)) begin
            ptr_e <= pick_e;
        end
    end
`else
    assign pick_e = e_req;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        own_e_n = own_e;
        tgt_n   = tgt_q;
        read_n  = read_q;
        addr_n  = bus_addr;
        wdata_n = bus_wdata;
        rdata_n = rdata;
        drive   = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (f_req | e_req) begin
                    state_n = S_ISSUE;
                    cnt_n   = 4'd1;
                    own_e_n = pick_e;
                    tgt_n   = pick_e ? e_tgt : f_tgt;
                    read_n  = pick_e ? e_read : f_read;
                    addr_n  = pick_e ? e_addr : f_addr;
                    wdata_n = pick_e ? e_wdata : f_wdata;
                    drive   = 1'b1;
                end
            end
            S_ISSUE: begin
                // acceptance wins over a timeout landing on the same edge
                if (!rdy) begin
                    state_n = S_WAIT;
                    cnt_n   = 4'd1;
                    drive   = 1'b1;
                end else if (cnt == TMO_C) begin
                    state_n = S_ERR;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                    drive = 1'b1;
                end
            end
            S_WAIT: begin
                if (rdy) begin
                    state_n = S_DONE;
                    fin     = 1'b1;
                    if (read_q) begin
                        rdata_n = bus_rdata;
                    end
                end else if (cnt == TMO_C) begin
                    state_n = S_ERR;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                    drive = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            own_e     <= 1'b0;
            tgt_q     <= 1'b0;
            read_q    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            f_gnt     <= 1'b0;
            e_gnt     <= 1'b0;
            f_done    <= 1'b0;
            e_done    <= 1'b0;
            f_err     <= 1'b0;
            e_err     <= 1'b0;
            cs_gpr    <= 1'b0;
            cs_ram    <= 1'b0;
            bus_read  <= 1'b0;
            bus_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            own_e     <= own_e_n;
            tgt_q     <= tgt_n;
            read_q    <= read_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            rdata     <= rdata_n;
            f_gnt     <= (drive | fin) & ~own_e_n;
            e_gnt     <= (drive | fin) & own_e_n;
            f_done    <= fin & ~own_e_n;
            e_done    <= fin & own_e_n;
            f_err     <= fin_err & ~own_e_n;
            e_err     <= fin_err & own_e_n;
            cs_gpr    <= drive & ~tgt_n;
            cs_ram    <= drive & tgt_n;
            bus_read  <= drive & read_n;
            bus_oe    <= drive & ~read_n;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed test-plan steps plus
// randomized transactions against a phase-level reference model.
module tb_mem_bus_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq[2];
    logic        tg[2];
    logic        rdf[2];
    logic [15:0] ad[2];
    logic [15:0] wd[2];
    logic        ready_gpr, ready_ram;
    logic [15:0] bus_rdata;

    logic        f_gnt, e_gnt, f_done, e_done, f_err, e_err;
    logic [15:0] rdata, bus_addr, bus_wdata;
    logic        cs_gpr, cs_ram, bus_read, bus_oe;

    int          checks = 0;
    int          errors = 0;
    bit          last_e;
    logic [15:0] exp_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .f_req(rq[0]),
        .f_tgt(tg[0]),
        .f_read(rdf[0]),
        .f_addr(ad[0]),
        .f_wdata(wd[0]),
        .e_req(rq[1]),
        .e_tgt(tg[1]),
        .e_read(rdf[1]),
        .e_addr(ad[1]),
        .e_wdata(wd[1]),
        .f_gnt(f_gnt),
        .e_gnt(e_gnt),
        .f_done(f_done),
        .e_done(e_done),
        .f_err(f_err),
        .e_err(e_err),
        .rdata(rdata),
        .cs_gpr(cs_gpr),
        .cs_ram(cs_ram),
        .bus_read(bus_read),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_oe(bus_oe),
        .ready_gpr(ready_gpr),
        .ready_ram(ready_ram),
        .bus_rdata(bus_rdata)
    );

    task automatic chk1(input string t, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, obs, exp);
        end
    endtask

    task automatic chk16(input string t, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec rule: a lone requester wins; ties go by priority or round-robin.
    function automatic bit pick();
        if (rq[1] && !rq[0]) return 1'b1;
        if (rq[0] && !rq[1]) return 1'b0;
`ifdef ARB_RR_EN
        return !last_e;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk_quiet(input string t);
        chk1({t, " f_gnt"}, f_gnt, 1'b0);
        chk1({t, " e_gnt"}, e_gnt, 1'b0);
        chk1({t, " f_done"}, f_done, 1'b0);
        chk1({t, " e_done"}, e_done, 1'b0);
        chk1({t, " f_err"}, f_err, 1'b0);
        chk1({t, " e_err"}, e_err, 1'b0);
        chk1({t, " cs_gpr"}, cs_gpr, 1'b0);
        chk1({t, " cs_ram"}, cs_ram, 1'b0);
        chk1({t, " bus_read"}, bus_read, 1'b0);
        chk1({t, " bus_oe"}, bus_oe, 1'b0);
        chk16({t, " rdata"}, rdata, exp_rdata);
    endtask

    task automatic chk_bus(input bit w, input logic xt, input logic xr,
                           input logic [15:0] xa, input logic [15:0] xd);
        chk1("bus f_gnt", f_gnt, !w);
        chk1("bus e_gnt", e_gnt, w);
        chk1("bus cs_gpr", cs_gpr, !xt);
        chk1("bus cs_ram", cs_ram, xt);
        chk1("bus bus_read", bus_read, xr);
        chk1("bus bus_oe", bus_oe, !xr);
        chk16("bus bus_addr", bus_addr, xa);
        chk16("bus bus_wdata", bus_wdata, xd);
        chk1("bus f_done", f_done, 1'b0);
        chk1("bus e_done", e_done, 1'b0);
        chk1("bus f_err", f_err, 1'b0);
        chk1("bus e_err", e_err, 1'b0);
        chk16("bus rdata", rdata, exp_rdata);
    endtask

    task automatic drive_rdy(input logic xt, input logic v);
        if (xt) begin
            ready_ram = v;
            ready_gpr = 1'($urandom);
        end else begin
            ready_gpr = v;
            ready_ram = 1'($urandom);
        end
    endtask

    // Owner's inputs change and req may drop mid-transaction; both must be ignored.
    task automatic scramble(input bit w);
        rq[w]     = 1'($urandom);
        tg[w]     = 1'($urandom);
        rdf[w]    = 1'($urandom);
        ad[w]     = 16'($urandom);
        wd[w]     = 16'($urandom);
        bus_rdata = 16'($urandom);
    endtask

    // Called in an IDLE cycle with requests set; returns at the negedge of
    // the following IDLE cycle. acc = ISSUE cycles target stays ready,
    // busy = WAIT cycles target stays busy; >= TMO means timeout.
    task automatic txn(input int acc, input int busy, input logic [15:0] rdv);
        bit w, to;
        logic xt, xr;
        logic [15:0] xa, xd;
        int ni, nw;
        w      = pick();
        last_e = w;
        xt = tg[w];
        xr = rdf[w];
        xa = ad[w];
        xd = wd[w];
        ready_gpr = 1'b1;
        ready_ram = 1'b1;
        step();
        to = (acc >= TMO);
        ni = to ? TMO : acc + 1;
        for (int i = 0; i < ni; i++) begin
            scramble(w);
            drive_rdy(xt, (i < acc));
            @(negedge clk);
            chk_bus(w, xt, xr, xa, xd);
            step();
        end
        if (!to) begin
            to = (busy >= TMO);
            nw = to ? TMO : busy + 1;
            for (int j = 0; j < nw; j++) begin
                scramble(w);
                drive_rdy(xt, (!to && j == busy));
                if (!to && j == busy) bus_rdata = rdv;
                @(negedge clk);
                chk_bus(w, xt, xr, xa, xd);
                step();
            end
        end
        @(negedge clk);
        if (!to && xr) exp_rdata = rdv;
        chk1("fin f_done", f_done, !w);
        chk1("fin e_done", e_done, w);
        chk1("fin f_err", f_err, to & !w);
        chk1("fin e_err", e_err, to & w);
        chk1("fin cs_gpr", cs_gpr, 1'b0);
        chk1("fin cs_ram", cs_ram, 1'b0);
        chk1("fin bus_oe", bus_oe, 1'b0);
        chk16("fin rdata", rdata, exp_rdata);
        if (!to) begin
            chk1("fin f_gnt", f_gnt, !w);
            chk1("fin e_gnt", e_gnt, w);
        end
        rq[w] = 1'b0;
        ready_gpr = 1'b1;
        ready_ram = 1'b1;
        step();
        @(negedge clk);
        chk_quiet("idle");
    endtask

    task automatic new_req(input int i);
        rq[i]  = 1'b1;
        tg[i]  = 1'($urandom);
        rdf[i] = 1'($urandom);
        ad[i]  = 16'($urandom);
        wd[i]  = 16'($urandom);
    endtask

    initial begin
        int acc, busy;
        for (int i = 0; i < 2; i++) begin
            rq[i]  = 1'b0;
            tg[i]  = 1'b0;
            rdf[i] = 1'b0;
            ad[i]  = '0;
            wd[i]  = '0;
        end
        ready_gpr = 1'b1;
        ready_ram = 1'b1;
        bus_rdata = '0;
        last_e    = 1'b1;
        exp_rdata = '0;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk16("reset bus_addr", bus_addr, 16'h0000);
        chk16("reset bus_wdata", bus_wdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // F read of GPR 0x0003
        rq[0] = 1'b1; tg[0] = 1'b0; rdf[0] = 1'b1; ad[0] = 16'h0003;
        txn(0, 0, 16'hA5A5);

        // E write to RAM 0x1234
        rq[1] = 1'b1; tg[1] = 1'b1; rdf[1] = 1'b0;
        ad[1] = 16'h1234; wd[1] = 16'hBEEF;
        txn(1, 2, 16'h0000);

        // continuous F and E requests
        new_req(0);
        new_req(1);
        for (int k = 0; k < 3; k++) begin
            rq[0] = 1'b1;
            rq[1] = 1'b1;
            txn(0, k, 16'($urandom));
        end
        while (rq[0] | rq[1]) txn(0, 0, 16'($urandom));

        // target never accepts
        rq[0] = 1'b1; tg[0] = 1'b0; rdf[0] = 1'b1; ad[0] = 16'h0007;
        txn(20, 0, 16'h1111);

        // target accepts but never returns ready
        rq[1] = 1'b1; tg[1] = 1'b1; rdf[1] = 1'b1; ad[1] = 16'h0100;
        txn(0, 20, 16'h2222);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 2; i++)
                if (!rq[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (!rq[0] && !rq[1]) new_req(int'($urandom_range(0, 1)));
            acc  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            busy = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
            txn(acc, busy, 16'($urandom));
        end
        while (rq[0] | rq[1]) txn(0, 0, 16'($urandom));

        // reset while in WAIT
        rq[0] = 1'b1; tg[0] = 1'b0; rdf[0] = 1'b1; ad[0] = 16'h0042;
        step();
        ready_gpr = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        last_e    = 1'b1;
        chk_quiet("async rst");
        rq[0] = 1'b0;
        ready_gpr = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk16("post rst bus_addr", bus_addr, 16'h0000);
        rq[0] = 1'b1; tg[0] = 1'b1; rdf[0] = 1'b1; ad[0] = 16'h0055;
        txn(0, 1, 16'h5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
